// File: rtl/axis_dot_product_pkg.sv
// ----------------------------------------------------------------------------
// axis_dot_product_pkg
// Shared definitions for the dot-product accumulator in the LCMV datapath:
// default widths, a packed result record for downstream stages, and a helper
// that sign-extends a product to the accumulator width.
// ----------------------------------------------------------------------------
package axis_dot_product_pkg;

    localparam int DEFAULT_GROWTH_BITS = 8;
    localparam int DEFAULT_DATA_WIDTH  = 32;
    localparam int DEFAULT_ACC_WIDTH   = 2 * DEFAULT_DATA_WIDTH + DEFAULT_GROWTH_BITS;
    localparam int DEFAULT_COUNT_WIDTH = 16;

    // Widest product/accumulator the helper below can handle.
    localparam int MAX_WIDTH = 128;

    typedef struct packed {
        logic [DEFAULT_ACC_WIDTH-1:0]   data;
        logic [DEFAULT_COUNT_WIDTH-1:0] count;
        logic                           error;
    } result_t;

    // Treat bit prod_width-1 of prod as the sign and replicate it upward.
    // Loop-variable indexing keeps every select constant after unrolling.
    function automatic logic [MAX_WIDTH-1:0] sext_prod(
        input logic [MAX_WIDTH-1:0] prod,
        input int                   prod_width
    );
        logic [MAX_WIDTH-1:0] ext;
        logic                 sign;
        sign = 1'b0;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            if (i == prod_width - 1) sign = prod[i];
        end
        for (int i = 0; i < MAX_WIDTH; i++) begin
            ext[i] = (i < prod_width) ? prod[i] : sign;
        end
        return ext;
    endfunction

endpackage

// File: rtl/signed_mult_reg.sv
// ----------------------------------------------------------------------------
// signed_mult_reg
// Registered signed multiplier with a sideband tag and a valid flag. Kept as a
// separate module so the product register maps cleanly onto a DSP block.
//   clk, rst     : clock, synchronous active-high reset (clears valid only)
//   load         : capture a*b and tag; valid goes high
//   drain        : the held product is consumed; valid drops unless reloaded
//   a, b         : signed operands
//   tag          : sideband bits travelling with the product
//   product      : registered full-width signed product
//   product_tag  : registered tag
//   valid        : product register holds an unconsumed product
// ----------------------------------------------------------------------------
module signed_mult_reg #(
    parameter int A_WIDTH   = 32,
    parameter int B_WIDTH   = 32,
    parameter int TAG_WIDTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load,
    input  logic                       drain,
    input  logic [A_WIDTH-1:0]         a,
    input  logic [B_WIDTH-1:0]         b,
    input  logic [TAG_WIDTH-1:0]       tag,
    output logic [A_WIDTH+B_WIDTH-1:0] product,
    output logic [TAG_WIDTH-1:0]       product_tag,
    output logic                       valid
);

    localparam int PROD_WIDTH = A_WIDTH + B_WIDTH;

    logic signed [PROD_WIDTH-1:0] a_ext;
    logic signed [PROD_WIDTH-1:0] b_ext;

    assign a_ext = PROD_WIDTH'($signed(a));
    assign b_ext = PROD_WIDTH'($signed(b));

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end

    // NOTE: the product and tag are pure datapath qualified by valid, so they
    // carry no reset; this keeps the register free to pack into the DSP.
    always_ff @(posedge clk) begin
        if (load) begin
            product     <= a_ext * b_ext;
            product_tag <= tag;
        end
    end

endmodule

// File: rtl/axis_dot_product_accumulator.sv
// ----------------------------------------------------------------------------
// axis_dot_product_accumulator
// Multiplies each accepted paired beat as signed integers and accumulates the
// products until a vector-end beat, then presents one result: the dot product,
// the beat count and a flag saying the two streams disagreed on the end beat.
//   clk, rst          : clock, synchronous active-high reset
//   input_valid/ready : paired-beat handshake (ready is high during reset)
//   input_data_1/2    : signed operands
//   input_last_1/2    : per-stream vector end; either one terminates a vector
//   output_valid/ready: result handshake; result holds while not accepted
//   output_data       : signed dot product, wraps modulo 2^ACC_WIDTH
//   output_count      : beats in the vector, modulo 2^COUNT_WIDTH
//   output_error      : last_1 != last_2 on the terminating beat
// ----------------------------------------------------------------------------
module axis_dot_product_accumulator
    import axis_dot_product_pkg::*;
#(
    parameter int DATA_WIDTH_1 = 32,
    parameter int DATA_WIDTH_2 = 32,
    parameter int ACC_WIDTH    = 72,
    parameter int COUNT_WIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   input_valid,
    output logic                   input_ready,
    input  logic [DATA_WIDTH_1-1:0] input_data_1,
    input  logic [DATA_WIDTH_2-1:0] input_data_2,
    input  logic                   input_last_1,
    input  logic                   input_last_2,
    output logic                   output_valid,
    input  logic                   output_ready,
    output logic [ACC_WIDTH-1:0]   output_data,
    output logic [COUNT_WIDTH-1:0] output_count,
    output logic                   output_error
);

    localparam int PROD_WIDTH = DATA_WIDTH_1 + DATA_WIDTH_2;

    logic                   p_valid;
    logic [PROD_WIDTH-1:0]  p_prod;
    logic [1:0]             p_tag;
    logic                   p_last;
    logic                   p_err;

    logic                   stall;
    logic                   accept;
    logic                   advance;

    logic [ACC_WIDTH-1:0]   acc;
    logic [COUNT_WIDTH-1:0] cnt;
    logic                   first;
    logic [ACC_WIDTH-1:0]   p_ext;
    logic [ACC_WIDTH-1:0]   acc_new;
    logic [COUNT_WIDTH-1:0] cnt_new;

    assign p_last = p_tag[1];
    assign p_err  = p_tag[0];

    // Only a terminating product can block: it needs the output register,
    // which is still occupied by an unaccepted result. Non-last products
    // keep draining into the accumulator meanwhile.
    assign stall       = p_valid && p_last && output_valid && !output_ready;
    assign input_ready = rst || !stall;
    assign accept      = input_valid && input_ready;
    assign advance     = p_valid && !stall;

    signed_mult_reg #(
        .A_WIDTH   (DATA_WIDTH_1),
        .B_WIDTH   (DATA_WIDTH_2),
        .TAG_WIDTH (2)
    ) u_mult (
        .clk         (clk),
        .rst         (rst),
        .load        (accept),
        .drain       (advance),
        .a           (input_data_1),
        .b           (input_data_2),
        .tag         ({input_last_1 | input_last_2, input_last_1 ^ input_last_2}),
        .product     (p_prod),
        .product_tag (p_tag),
        .valid       (p_valid)
    );

    assign p_ext   = ACC_WIDTH'(sext_prod(MAX_WIDTH'(p_prod), PROD_WIDTH));
    // "first" restarts the sum here rather than clearing acc on the last beat,
    // so a new vector can follow a last beat with no bubble.
    assign acc_new = (first ? '0 : acc) + p_ext;
    assign cnt_new = first ? COUNT_WIDTH'(1) : cnt + COUNT_WIDTH'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            acc          <= '0;
            cnt          <= '0;
            first        <= 1'b1;
            output_valid <= 1'b0;
            output_data  <= '0;
            output_count <= '0;
            output_error <= 1'b0;
        end else begin
            if (output_valid && output_ready) begin
                output_valid <= 1'b0;
            end
            // NOTE: with non-blocking assignments the later write to
            // output_valid in this block wins, so a result loading in the
            // same cycle the previous one is taken keeps output_valid high.
            if (advance) begin
                acc <= acc_new;
                cnt <= cnt_new;
                if (p_last) begin
                    output_data  <= acc_new;
                    output_count <= cnt_new;
                    output_error <= p_err;
                    output_valid <= 1'b1;
                    first        <= 1'b1;
                end else begin
                    first <= 1'b0;
                end
            end
        end
    end

endmodule
